// File: rtl/inst_queue_pkg.sv
// Shared widths, constants and the queue slot payload type for the instruction queue.
package inst_queue_pkg;

    localparam int unsigned IQ_SIZE_LOG_DEF = 4;
    localparam int unsigned IQ_SIZE_DEF     = 1 << IQ_SIZE_LOG_DEF;
    localparam int unsigned XLEN            = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] btb_pc;
        logic            btb_predict;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetcher/decoder/ROB side bundle of the instruction queue; the queue itself is the slave.
interface inst_queue_if;
    import inst_queue_pkg::*;

    logic            rdy;
    logic            Fetch_flag;
    logic [XLEN-1:0] Fetch_inst;
    logic [XLEN-1:0] Fetch_PC;
    logic [XLEN-1:0] Fetch_BTB_PC;
    logic            Fetch_BTB_predict;
    logic            IQ_full;
    logic            IQ_flag;
    logic [XLEN-1:0] IQ_inst;
    logic [XLEN-1:0] IQ_PC;
    logic [XLEN-1:0] IQ_BTB_PC;
    logic            IQ_BTB_predict;
    logic            Dec_flag;
    logic            ROB_clear;

    modport master (
        output rdy, Fetch_flag, Fetch_inst, Fetch_PC, Fetch_BTB_PC, Fetch_BTB_predict,
               Dec_flag, ROB_clear,
        input  IQ_full, IQ_flag, IQ_inst, IQ_PC, IQ_BTB_PC, IQ_BTB_predict
    );

    modport slave (
        input  rdy, Fetch_flag, Fetch_inst, Fetch_PC, Fetch_BTB_PC, Fetch_BTB_predict,
               Dec_flag, ROB_clear,
        output IQ_full, IQ_flag, IQ_inst, IQ_PC, IQ_BTB_PC, IQ_BTB_predict
    );

endinterface

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode; head entry is presented combinationally
// and the whole queue is discarded in one cycle on a ROB flush.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned IQ_SIZE_LOG = IQ_SIZE_LOG_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_queue_if.slave  bus
);

    localparam int unsigned IQ_SIZE = 1 << IQ_SIZE_LOG;
    localparam int unsigned IW      = IQ_SIZE_LOG;
    localparam int unsigned CW      = IQ_SIZE_LOG + 1;

    logic [IW-1:0] head_q, head_d;
    logic [IW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    iq_entry_t     slot_q [IQ_SIZE];
    iq_entry_t     slot_d [IQ_SIZE];

    logic      pop;
    logic      push;
    iq_entry_t wr_entry;
    iq_entry_t head_entry;

    // Next-state: flush wins over push/pop, and rdy low holds everything.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        slot_d   = slot_q;
        pop      = bus.Dec_flag && (count_q != '0);
        push     = bus.Fetch_flag && ((count_q != CW'(IQ_SIZE)) || pop);
        wr_entry = '{inst:        bus.Fetch_inst,
                     pc:          bus.Fetch_PC,
                     btb_pc:      bus.Fetch_BTB_PC,
                     btb_predict: bus.Fetch_BTB_predict};
        if (bus.rdy == TRUE) begin
            if (bus.ROB_clear == TRUE) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push) begin
                    slot_d[tail_q] = wr_entry;
                    tail_d         = tail_q + IW'(1);
                end
                if (pop) begin
                    head_d = head_q + IW'(1);
                end
                if (push && !pop) begin
                    count_d = count_q + CW'(1);
                end else if (pop && !push) begin
                    count_d = count_q - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < IQ_SIZE; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            slot_q  <= slot_d;
        end
    end

    // Full asserts one slot early so a push already in flight from the fetcher still fits.
    always_comb begin
        head_entry         = slot_q[head_q];
        bus.IQ_flag        = (count_q != '0);
        bus.IQ_full        = (count_q >= CW'(IQ_SIZE - 1));
        bus.IQ_inst        = head_entry.inst;
        bus.IQ_PC          = head_entry.pc;
        bus.IQ_BTB_PC      = head_entry.btb_pc;
        bus.IQ_BTB_predict = head_entry.btb_predict;
    end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: a queue-based reference model tracks accepted entries and a
// negedge monitor compares the DUT head against the oldest expected entry.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int unsigned DEPTH = IQ_SIZE_DEF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    inst_queue_if u_if();

    inst_queue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    int        n_tests     = 0;
    int        n_fail      = 0;
    int        drop_cnt    = 0;
    bit        pop_pending = 1'b0;
    iq_entry_t exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: check head/flags against the model, and retire the head when the decoder takes it.
    always @(negedge clk) begin
        if (rst_n) begin
            check("iq_flag", 32'(u_if.IQ_flag), 32'(exp_q.size() != 0));
            check("iq_full", 32'(u_if.IQ_full), 32'(exp_q.size() >= int'(DEPTH - 1)));
            if (exp_q.size() != 0) begin
                check("head_inst",    u_if.IQ_inst,               exp_q[0].inst);
                check("head_pc",      u_if.IQ_PC,                 exp_q[0].pc);
                check("head_btb_pc",  u_if.IQ_BTB_PC,             exp_q[0].btb_pc);
                check("head_predict", 32'(u_if.IQ_BTB_predict),   32'(exp_q[0].btb_predict));
            end
            if (u_if.rdy && !u_if.ROB_clear && u_if.Dec_flag && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                pop_pending = 1'b1;
            end
        end
    end

    // Model: accept pushes that fit, flush on ROB_clear, and flag pushes dropped at full.
    always @(posedge clk) begin
        if (rst_n && u_if.rdy) begin
            if (u_if.ROB_clear) begin
                exp_q.delete();
            end else if (u_if.Fetch_flag) begin
                if (exp_q.size() != int'(DEPTH) || pop_pending) begin
                    exp_q.push_back('{inst: u_if.Fetch_inst, pc: u_if.Fetch_PC,
                                      btb_pc: u_if.Fetch_BTB_PC,
                                      btb_predict: u_if.Fetch_BTB_predict});
                end else begin
                    drop_cnt++;
                    $display("[TB] protocol: push dropped while queue full at %0t", $time);
                end
            end
        end
        pop_pending = 1'b0;
    end

    always @(negedge rst_n) begin
        exp_q.delete();
        pop_pending = 1'b0;
    end

    task automatic drive(input bit f, input logic [31:0] pc, input logic [31:0] inst,
                         input bit dec, input bit clr);
        u_if.Fetch_flag        = f;
        u_if.Fetch_PC          = pc;
        u_if.Fetch_inst        = inst;
        u_if.Fetch_BTB_PC      = pc + 32'd4;
        u_if.Fetch_BTB_predict = pc[2];
        u_if.Dec_flag          = dec;
        u_if.ROB_clear         = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        u_if.rdy = 1'b1;
        u_if.Fetch_flag = 1'b0;
        u_if.Fetch_inst = '0;
        u_if.Fetch_PC = '0;
        u_if.Fetch_BTB_PC = '0;
        u_if.Fetch_BTB_predict = 1'b0;
        u_if.Dec_flag = 1'b0;
        u_if.ROB_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flag",    32'(u_if.IQ_flag), 32'd0);
        check("rst_full",    32'(u_if.IQ_full), 32'd0);
        check("rst_inst",    u_if.IQ_inst, 32'd0);
        check("rst_pc",      u_if.IQ_PC, 32'd0);
        check("rst_btb_pc",  u_if.IQ_BTB_PC, 32'd0);
        check("rst_predict", 32'(u_if.IQ_BTB_predict), 32'd0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);

        // Single push then pop
        drive(1, 32'h0, 32'h0000_0013, 0, 0);
        check("first_flag", 32'(u_if.IQ_flag), 32'd1);
        check("first_inst", u_if.IQ_inst, 32'h0000_0013);
        drive(0, 0, 0, 1, 0);
        check("first_pop_flag", 32'(u_if.IQ_flag), 32'd0);

        // Fill to full, one dropped push, then drain in order
        for (int i = 0; i < 15; i++) drive(1, 32'(i * 4), $urandom, 0, 0);
        check("full_at_15", 32'(u_if.IQ_full), 32'd1);
        drive(1, 32'h3C, $urandom, 0, 0);
        drive(1, 32'h40, $urandom, 0, 0);
        check("drop_count", 32'(drop_cnt), 32'd1);
        check("full_head_pc", u_if.IQ_PC, 32'h0);
        for (int i = 0; i < 16; i++) drive(0, 0, 0, 1, 0);
        check("drained_flag", 32'(u_if.IQ_flag), 32'd0);

        // Streaming push+pop at count 1, wrapping pointers twice
        drive(1, 32'h200, $urandom, 0, 0);
        for (int i = 0; i < 40; i++) drive(1, 32'h204 + 32'(i * 4), $urandom, 1, 0);
        check("stream_head_pc", u_if.IQ_PC, 32'h200 + 32'd160);
        drive(0, 0, 0, 1, 0);

        // Push+pop while completely full
        for (int i = 0; i < 16; i++) drive(1, 32'h400 + 32'(i * 4), $urandom, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 32'h440 + 32'(i * 4), $urandom, 1, 0);
        check("full_pushpop_full", 32'(u_if.IQ_full), 32'd1);
        check("full_pushpop_head", u_if.IQ_PC, 32'h414);
        for (int i = 0; i < 16; i++) drive(0, 0, 0, 1, 0);

        // Flush at count 7 with a concurrent push and pop
        for (int i = 0; i < 7; i++) drive(1, 32'h800 + 32'(i * 4), $urandom, 0, 0);
        drive(1, 32'h999, $urandom, 1, 1);
        check("flush_flag", 32'(u_if.IQ_flag), 32'd0);
        check("flush_full", 32'(u_if.IQ_full), 32'd0);
        drive(1, 32'h100, $urandom, 0, 0);
        check("post_flush_pc", u_if.IQ_PC, 32'h100);
        drive(0, 0, 0, 1, 0);

        // rdy low freezes state despite push/pop/flush activity
        for (int i = 0; i < 4; i++) drive(1, 32'hA00 + 32'(i * 4), $urandom, 0, 0);
        u_if.rdy = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'($urandom), 32'hB00, $urandom, 1'($urandom), 1'(i == 2));
        check("frozen_pc", u_if.IQ_PC, 32'hA00);
        u_if.rdy = 1'b1;

        // Randomised traffic with a well-behaved fetcher
        for (int i = 0; i < 400; i++) begin
            u_if.rdy = 1'(($urandom % 8) != 0);
            drive(!u_if.IQ_full && 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom,
                  1'($urandom), 1'(($urandom % 32) == 0));
        end
        u_if.rdy = 1'b1;

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 3; i++) drive(1, 32'hC00 + 32'(i * 4), $urandom, 0, 0);
        check("pre_reset_flag", 32'(u_if.IQ_flag), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_flag", 32'(u_if.IQ_flag), 32'd0);
        check("async_rst_pc",   u_if.IQ_PC, 32'd0);
        drive(1, 32'hD00, $urandom, 1, 0);
        drive(1, 32'hD04, $urandom, 1, 0);
        check("in_reset_flag", 32'(u_if.IQ_flag), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            drive(!u_if.IQ_full && 1'($urandom), $urandom, $urandom, 1'($urandom), 1'b0);
        end
        for (int i = 0; i < 18; i++) drive(0, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Circular instruction queue between the fetcher and the decoder. Buffers fetched instructions with their PC and BTB prediction, and presents the oldest entry to the decoder combinationally. Entries retire on the decoder's `Dec_flag`. The queue empties in one cycle on a ROB misprediction clear.

## Interface
- `IQ_SIZE_LOG`, default 4: log2 of depth; `IQ_SIZE = 1 << IQ_SIZE_LOG` = 16 entries.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rdy` in 1: global ready; low freezes all state.
- `Fetch_flag` in 1: push request, one instruction this cycle.
- `Fetch_inst` in 32: instruction word.
- `Fetch_PC` in 32: PC of the instruction.
- `Fetch_BTB_PC` in 32: predicted next PC.
- `Fetch_BTB_predict` in 1: BTB predicted taken.
- `IQ_full` out 1: fetcher must not push next cycle.
- `IQ_flag` out 1: head entry valid.
- `IQ_inst` out 32: head instruction word.
- `IQ_PC` out 32: head PC.
- `IQ_BTB_PC` out 32: head predicted next PC.
- `IQ_BTB_predict` out 1: head taken prediction.
- `Dec_flag` in 1: decoder consumed the head this cycle.
- `ROB_clear` in 1: misprediction flush.

## Operation
- Storage: `IQ_SIZE` slots, each holding {inst[31:0], PC[31:0], BTB_PC[31:0], BTB_predict}.
- State: `head` and `tail` (IQ_SIZE_LOG bits, wrap modulo IQ_SIZE), and `count` (IQ_SIZE_LOG+1 bits, 0..IQ_SIZE).
- pop = `Dec_flag && count != 0`. `Dec_flag` while empty is ignored.
- push = `Fetch_flag && (count != IQ_SIZE || pop)`.
  - A push while count == IQ_SIZE with no pop is dropped.
  - A dropped push is a protocol violation and is flagged by a bench assertion.
- Push writes slot[tail] and advances tail by 1. Pop advances head by 1.
- count update:
  - push only: count + 1.
  - pop only: count − 1.
  - push and pop together: unchanged.
- Push and pop in the same cycle are legal at any occupancy, including count == 1 and count == IQ_SIZE.
- `ROB_clear` has priority over push and pop. When it is high with `rdy` high, the next edge sets head = tail = count = 0 and discards same-cycle push and pop. Slot contents are not cleared.
- `rdy` low: no state changes, including flush. Outputs keep tracking the held state.
- Outputs:
  - `IQ_flag = (count != 0)`.
  - `IQ_inst`, `IQ_PC`, `IQ_BTB_PC` and `IQ_BTB_predict` are slot[head], combinational. They are don't-care when `IQ_flag` is 0.
  - `IQ_full = (count >= IQ_SIZE − 1)`. This one-slot slack covers the fetcher's registered push.

## Timing
- Reset (async, `rst_n` low): head = tail = count = 0 and all slots cleared to 0.
  - Output values during reset: `IQ_flag` = 0, `IQ_full` = 0, and all data outputs = 0.
- Push-to-visible latency is 1 cycle. An entry pushed at edge N drives `IQ_flag` and head outputs after edge N if the queue was empty. There is no bypass from `Fetch_*` to `IQ_*`.
- Pop takes effect at the edge where `Dec_flag` is high. The next entry is on the outputs immediately after that edge.
- `IQ_full` is derived from registered count. It rises in the cycle after the push that makes count = IQ_SIZE − 1 and falls in the cycle after the pop that makes count = IQ_SIZE − 2.
- Flush: `IQ_flag` = 0 and `IQ_full` = 0 in the cycle after the edge where `ROB_clear` was sampled. A push in the cycle after the flush is accepted normally.
- Reset asserted mid-operation discards all entries asynchronously. No push or pop is honoured while `rst_n` is low.

## Structure
- Add to `define.v`: `IQ_SIZE_LOG`, `IQ_SIZE`, and `` `IQ_INDEX_RANGE `` (IQ_SIZE_LOG−1:0).
- Reuse the existing `` `TRUE `` and `` `FALSE `` constants.
- No sub-module. Pointer/count logic and slot arrays are inline in one module.
- One sequential block holds the state; one combinational block drives the outputs.

## Test plan
- Reset, then push inst 0x00000013 at PC 0x0, BTB_PC 0x4, predict 0 → next cycle `IQ_flag` = 1, `IQ_inst` = 0x00000013, `IQ_PC` = 0; one `Dec_flag` pulse → `IQ_flag` = 0.
- 15 consecutive pushes with no pops → `IQ_full` = 1 after the 15th edge. A 16th push is accepted (count = 16). A 17th push with no pop is dropped and the bench assertion fires. Sixteen pops return PCs 0x0, 0x4, … 0x3C in order.
- Continuous push+pop at count = 1 for 40 cycles, so pointers wrap twice → count stays 1 and the head PC increments by 4 each cycle.
- Push while count = 16 and `Dec_flag` = 1 → accepted; count stays 16; FIFO order is preserved.
- Queue at count = 7, `ROB_clear` = 1 together with `Fetch_flag` and `Dec_flag` → next cycle count = 0, `IQ_flag` = 0, `IQ_full` = 0. A push at PC 0x100 the following cycle appears at head.
- `rdy` = 0 for 5 cycles with pushes and pops driven → count, head and outputs are unchanged. Pull `rst_n` low mid-sequence → `IQ_flag` = 0 immediately, without waiting for a clock edge.
